// File: rtl/muldiv_unit_if.sv
// Request/result bundle between the register file / control path and the multiply-divide unit.
// Signal names are written from the unit's point of view.
interface muldiv_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic             i_start;
    logic [1:0]       i_op;
    logic [WIDTH-1:0] i_a;
    logic [WIDTH-1:0] i_b;
    logic             i_hi_we;
    logic             i_lo_we;
    logic             o_busy;
    logic             o_done;
    logic [WIDTH-1:0] o_hi;
    logic [WIDTH-1:0] o_lo;

    modport master (
        output i_start, i_op, i_a, i_b, i_hi_we, i_lo_we,
        input  o_busy, o_done, o_hi, o_lo
    );

    modport slave (
        input  i_start, i_op, i_a, i_b, i_hi_we, i_lo_we,
        output o_busy, o_done, o_hi, o_lo
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers: 32 shift-add or restoring-divide
// steps on operand magnitudes, then one cycle of sign fix-up and special-case override.
module muldiv_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic           i_clk,
    input  logic           i_rst,
    muldiv_unit_if.slave   bus
);
    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LastCnt = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

    state_e             r_state, w_state_d;
    logic [CNT_W-1:0]   r_cnt, w_cnt_d;
    logic               r_is_div, w_is_div_d;
    logic               r_neg_res, w_neg_res_d;
    logic               r_neg_rem, w_neg_rem_d;
    logic               r_div_zero, w_div_zero_d;
    logic [WIDTH-1:0]   r_opnd, w_opnd_d;
    logic [WIDTH-1:0]   r_a_orig, w_a_orig_d;
    logic [2*WIDTH-1:0] r_acc, w_acc_d;
    logic [WIDTH-1:0]   r_hi, w_hi_d;
    logic [WIDTH-1:0]   r_lo, w_lo_d;
    logic               r_busy, w_busy_d;
    logic               r_done, w_done_d;

    // Operand magnitudes; unsigned ops never see a negative sign.
    logic             w_signed, w_a_neg, w_b_neg;
    logic [WIDTH-1:0] w_a_mag, w_b_mag;

    assign w_signed = ~bus.i_op[0];
    assign w_a_neg  = w_signed & bus.i_a[WIDTH-1];
    assign w_b_neg  = w_signed & bus.i_b[WIDTH-1];
    assign w_a_mag  = w_a_neg ? (~bus.i_a + WIDTH'(1)) : bus.i_a;
    assign w_b_mag  = w_b_neg ? (~bus.i_b + WIDTH'(1)) : bus.i_b;

    // Multiply step: add multiplicand into the upper half when the multiplier LSB is set,
    // then shift the whole accumulator right with the carry.
    logic [WIDTH:0] w_sum;
    assign w_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, (r_acc[0] ? r_opnd : '0)};

    // Divide step: upper half holds the remainder, lower half shifts dividend out / quotient in.
    logic [WIDTH:0] w_shift, w_diff;
    logic           w_qbit;
    assign w_shift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_diff  = w_shift - {1'b0, r_opnd};
    assign w_qbit  = ~w_diff[WIDTH];

    logic [2*WIDTH-1:0] w_iter;
    assign w_iter = !r_is_div ? {w_sum, r_acc[WIDTH-1:1]} :
                    w_qbit    ? {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1} :
                                {w_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};

    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo, w_rem;
    assign w_prod = r_neg_res ? (~r_acc + (2*WIDTH)'(1)) : r_acc;
    assign w_quo  = r_neg_res ? (~r_acc[WIDTH-1:0] + WIDTH'(1)) : r_acc[WIDTH-1:0];
    assign w_rem  = r_neg_rem ? (~r_acc[2*WIDTH-1:WIDTH] + WIDTH'(1)) : r_acc[2*WIDTH-1:WIDTH];

    always_comb begin
        w_state_d    = r_state;
        w_cnt_d      = r_cnt;
        w_is_div_d   = r_is_div;
        w_neg_res_d  = r_neg_res;
        w_neg_rem_d  = r_neg_rem;
        w_div_zero_d = r_div_zero;
        w_opnd_d     = r_opnd;
        w_a_orig_d   = r_a_orig;
        w_acc_d      = r_acc;
        w_hi_d       = r_hi;
        w_lo_d       = r_lo;
        w_done_d     = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (bus.i_start) begin
                    w_state_d    = StCalc;
                    w_cnt_d      = '0;
                    w_is_div_d   = bus.i_op[1];
                    w_neg_res_d  = w_a_neg ^ w_b_neg;
                    w_neg_rem_d  = w_a_neg;
                    w_div_zero_d = (bus.i_b == '0);
                    w_a_orig_d   = bus.i_a;
                    w_opnd_d     = bus.i_op[1] ? w_b_mag : w_a_mag;
                    w_acc_d      = {{WIDTH{1'b0}}, (bus.i_op[1] ? w_a_mag : w_b_mag)};
                end else begin
                    if (bus.i_hi_we) w_hi_d = bus.i_a;
                    if (bus.i_lo_we) w_lo_d = bus.i_a;
                end
            end
            StCalc: begin
                w_acc_d = w_iter;
                w_cnt_d = r_cnt + CNT_W'(1);
                if (r_cnt == LastCnt) w_state_d = StFix;
            end
            StFix: begin
                w_state_d = StIdle;
                w_done_d  = 1'b1;
                if (!r_is_div) begin
                    {w_hi_d, w_lo_d} = w_prod;
                end else if (r_div_zero) begin
                    w_hi_d = r_a_orig;
                    w_lo_d = '1;
                end else begin
                    w_hi_d = w_rem;
                    w_lo_d = w_quo;
                end
            end
            default: w_state_d = StIdle;
        endcase
        w_busy_d = (w_state_d != StIdle);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= StIdle;
            r_cnt      <= '0;
            r_is_div   <= 1'b0;
            r_neg_res  <= 1'b0;
            r_neg_rem  <= 1'b0;
            r_div_zero <= 1'b0;
            r_opnd     <= '0;
            r_a_orig   <= '0;
            r_acc      <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_cnt      <= w_cnt_d;
            r_is_div   <= w_is_div_d;
            r_neg_res  <= w_neg_res_d;
            r_neg_rem  <= w_neg_rem_d;
            r_div_zero <= w_div_zero_d;
            r_opnd     <= w_opnd_d;
            r_a_orig   <= w_a_orig_d;
            r_acc      <= w_acc_d;
            r_hi       <= w_hi_d;
            r_lo       <= w_lo_d;
            r_busy     <= w_busy_d;
            r_done     <= w_done_d;
        end
    end

    assign bus.o_busy = r_busy;
    assign bus.o_done = r_done;
    assign bus.o_hi   = r_hi;
    assign bus.o_lo   = r_lo;
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases plus random ops, each result
// compared against plain-arithmetic HI/LO expectations.
module tb_muldiv_unit;
    logic clk = 1'b0;
    logic rst;

    muldiv_unit_if #(.WIDTH(32)) bus ();

    muldiv_unit #(.WIDTH(32)) u_dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int          n_total = 0;
    int          n_bad   = 0;
    logic [31:0] cur_hi  = '0;
    logic [31:0] cur_lo  = '0;
    logic [31:0] pend_hi = '0;
    logic [31:0] pend_lo = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    function automatic logic [63:0] ref_model(input logic [1:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        longint sp;
        int     sa, sb, q, r;
        case (op)
            2'b00: begin
                sp = longint'($signed(a)) * longint'($signed(b));
                return 64'(sp);
            end
            2'b01: return {32'd0, a} * {32'd0, b};
            2'b10: begin
                if (b == 32'd0) return {a, 32'hffff_ffff};
                if (a == 32'h8000_0000 && b == 32'hffff_ffff) return {32'd0, 32'h8000_0000};
                sa = $signed(a);
                sb = $signed(b);
                q  = sa / sb;
                r  = sa % sb;
                return {32'(r), 32'(q)};
            end
            default: begin
                if (b == 32'd0) return {a, 32'hffff_ffff};
                return {a % b, a / b};
            end
        endcase
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hffff_ffff;
            3:       return 32'd1;
            default: return $urandom;
        endcase
    endfunction

    // Called at a negedge; returns at the negedge after the acceptance edge.
    task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.i_start = 1'b1;
        bus.i_op    = op;
        bus.i_a     = a;
        bus.i_b     = b;
        {pend_hi, pend_lo} = ref_model(op, a, b);
        @(posedge clk);
        @(negedge clk);
        bus.i_start = 1'b0;
    endtask

    task automatic wait_done(input int poke_at, input int hiwe_at, output int cycles,
                             output bit changed);
        cycles  = 0;
        changed = 1'b0;
        while (bus.o_busy && cycles < 100) begin
            if (bus.o_hi !== cur_hi || bus.o_lo !== cur_lo) changed = 1'b1;
            if (cycles == poke_at) begin
                bus.i_start = 1'b1;
                bus.i_op    = 2'b01;
                bus.i_a     = $urandom;
                bus.i_b     = $urandom;
            end
            if (cycles == hiwe_at) begin
                bus.i_hi_we = 1'b1;
                bus.i_a     = 32'hdead_beef;
            end
            if (cycles == poke_at + 1 || cycles == hiwe_at + 1) begin
                bus.i_start = 1'b0;
                bus.i_hi_we = 1'b0;
            end
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic finish_check(input string tag, input int cycles, input bit changed);
        check({tag, ".busy_cycles"}, 32'(cycles), 32'd33);
        check({tag, ".hilo_held"}, 32'(changed), 32'd0);
        check({tag, ".done"}, 32'(bus.o_done), 32'd1);
        check({tag, ".hi"}, bus.o_hi, pend_hi);
        check({tag, ".lo"}, bus.o_lo, pend_lo);
        cur_hi = pend_hi;
        cur_lo = pend_lo;
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b);
        int cycles;
        bit changed;
        launch(op, a, b);
        wait_done(-1, -1, cycles, changed);
        finish_check(tag, cycles, changed);
        @(negedge clk);
        check({tag, ".done_fall"}, 32'(bus.o_done), 32'd0);
    endtask

    initial begin
        int cycles;
        bit changed;
        bit seen;
        logic [1:0]  op;
        logic [31:0] a, b;

        rst         = 1'b1;
        bus.i_start = 1'b0;
        bus.i_op    = 2'b00;
        bus.i_a     = '0;
        bus.i_b     = '0;
        bus.i_hi_we = 1'b0;
        bus.i_lo_we = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst.busy", 32'(bus.o_busy), 32'd0);
        check("rst.done", 32'(bus.o_done), 32'd0);
        check("rst.hi", bus.o_hi, 32'd0);
        check("rst.lo", bus.o_lo, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_op("multu_max", 2'b01, 32'hffff_ffff, 32'hffff_ffff);
        run_op("mult_neg", 2'b00, 32'hffff_fffd, 32'h0000_0007);
        run_op("div_neg", 2'b10, 32'hffff_fff9, 32'h0000_0002);
        run_op("divu_small", 2'b11, 32'd7, 32'd2);
        run_op("div_zero", 2'b10, 32'h1234_5678, 32'd0);
        run_op("divu_zero", 2'b11, 32'h8000_0000, 32'd0);
        run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hffff_ffff);
        run_op("mult_minmin", 2'b00, 32'h8000_0000, 32'h8000_0000);

        // Start pulse mid-CALC must be ignored.
        launch(2'b11, 32'd100, 32'd7);
        wait_done(5, -1, cycles, changed);
        finish_check("ignored_start", cycles, changed);
        @(negedge clk);

        // MTHI while busy must be dropped.
        launch(2'b00, 32'h0001_0000, 32'hffff_0003);
        wait_done(-1, 8, cycles, changed);
        finish_check("hiwe_busy", cycles, changed);
        @(negedge clk);

        // MTLO in idle.
        bus.i_lo_we = 1'b1;
        bus.i_a     = 32'ha5a5_a5a5;
        @(posedge clk);
        @(negedge clk);
        bus.i_lo_we = 1'b0;
        cur_lo = 32'ha5a5_a5a5;
        check("mtlo.lo", bus.o_lo, cur_lo);
        check("mtlo.hi", bus.o_hi, cur_hi);

        // Start has priority over simultaneous MTHI/MTLO.
        bus.i_hi_we = 1'b1;
        bus.i_lo_we = 1'b1;
        launch(2'b01, 32'd3, 32'd9);
        bus.i_hi_we = 1'b0;
        bus.i_lo_we = 1'b0;
        wait_done(-1, -1, cycles, changed);
        finish_check("start_prio", cycles, changed);
        @(negedge clk);

        // MTHI and MTLO together.
        bus.i_hi_we = 1'b1;
        bus.i_lo_we = 1'b1;
        bus.i_a     = 32'h1357_9bdf;
        @(posedge clk);
        @(negedge clk);
        bus.i_hi_we = 1'b0;
        bus.i_lo_we = 1'b0;
        cur_hi = 32'h1357_9bdf;
        cur_lo = 32'h1357_9bdf;
        check("mt_both.hi", bus.o_hi, cur_hi);
        check("mt_both.lo", bus.o_lo, cur_lo);

        // Back-to-back: second start held during the done cycle.
        launch(2'b10, 32'hffff_ff00, 32'd13);
        wait_done(-1, -1, cycles, changed);
        finish_check("b2b_first", cycles, changed);
        launch(2'b00, 32'h7fff_ffff, 32'h7fff_ffff);
        check("b2b.done_fall", 32'(bus.o_done), 32'd0);
        check("b2b.busy", 32'(bus.o_busy), 32'd1);
        check("b2b.hi_held", bus.o_hi, cur_hi);
        check("b2b.lo_held", bus.o_lo, cur_lo);
        wait_done(-1, -1, cycles, changed);
        finish_check("b2b_second", cycles, changed);
        @(negedge clk);

        // Reset in the middle of CALC.
        launch(2'b01, 32'hdead_beef, 32'hcafe_f00d);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        cur_hi = '0;
        cur_lo = '0;
        check("midrst.busy", 32'(bus.o_busy), 32'd0);
        check("midrst.done", 32'(bus.o_done), 32'd0);
        check("midrst.hi", bus.o_hi, 32'd0);
        check("midrst.lo", bus.o_lo, 32'd0);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus.o_done) seen = 1'b1;
        end
        check("midrst.no_done", 32'(seen), 32'd0);
        run_op("after_rst", 2'b01, 32'd3, 32'd5);

        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = pick();
            b  = pick();
            run_op($sformatf("rand%0d_op%0d_%h_%h", i, op, a, b), op, a, b);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative 32-bit multiply/divide unit for the single-cycle CPU, sitting directly downstream of the register file. It consumes the two register read operands and executes MULT, MULTU, DIV and DIVU over multiple cycles into dedicated HI/LO registers. It also handles MTHI/MTLO writes. The control path stalls on `busy`, and MFHI/MFLO results return to the register-file write-data mux from `hi`/`lo`.

## Interface
- `WIDTH`, 32: operand width; `CNT_W = $clog2(WIDTH)` derived, not overridable.
- `clk`  in  1  rising-edge clock, sole clock domain.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  launch operation; sampled only when `busy`=0.
- `op`  in  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `a`  in  WIDTH  operand A / dividend, from the register-file RD1.
- `b`  in  WIDTH  operand B / divisor, from the register-file RD2.
- `hi_we`  in  1  MTHI: `hi` <= `a`.
- `lo_we`  in  1  MTLO: `lo` <= `a`.
- `busy`  out  1  operation in progress; the CPU stalls any muldiv/MFHI/MFLO instruction while high.
- `done`  out  1  one-cycle pulse; `hi`/`lo` hold the new result.
- `hi`  out  WIDTH  HI register: product upper half / remainder.
- `lo`  out  WIDTH  LO register: product lower half / quotient.

## Operation
- States:
  - IDLE: `busy`=0.
  - CALC: 32 iterations; counter runs 0..31.
  - FIX: sign correction and special cases; writes HI/LO.
- IDLE -> CALC on `start`=1:
  - Latch `op` and operand magnitudes.
  - Signed ops latch |a| and |b| and record the result signs.
  - Unsigned ops latch raw values.
- CALC -> FIX after the iteration with counter=31. FIX -> IDLE always.
- Multiply: radix-2 shift-add, one partial product per cycle, 64-bit accumulator.
- Divide: restoring algorithm, one quotient bit per cycle, 33-bit partial remainder.
- FIX sign rules (signed ops only):
  - Product is negated (64-bit two's complement) iff sign(a) != sign(b).
  - Quotient is negated iff sign(a) != sign(b).
  - Remainder takes the sign of the dividend.
  - |0x80000000| is the unsigned value 0x80000000. There is no saturation.
- Divide by zero (b=0, DIV or DIVU): override to HI = original `a`, LO = 0xFFFFFFFF.
- Signed overflow (DIV 0x80000000 / 0xFFFFFFFF): LO=0x80000000, HI=0, with no trap.
- `start` while `busy`=1: ignored. The operation in flight is unaffected.
- `hi_we`/`lo_we`:
  - Honoured only in IDLE with `start`=0.
  - Dropped if `busy`=1 or `start`=1 in the same cycle; `start` has priority.
  - Both may assert together.
- `hi`/`lo` change only on reset, MTHI/MTLO, or the FIX->IDLE edge. The CPU sees no intermediate values.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `hi`=0, `lo`=0, counter=0.
- Reset mid-operation aborts on the next edge with the same values. The result is discarded and `done` does not pulse.
- Call the `start` acceptance edge E0.
  - `busy`=1 from after E0 through the cycle before E33, i.e. 33 cycles: 32 CALC + 1 FIX.
  - Edge E33 writes `hi`/`lo`, sets `done`=1 and clears `busy`.
  - `done` falls at E34.
  - Fixed latency of 33 cycles, independent of operand values and of `op`.
- Back-to-back operation:
  - `start`=1 in the cycle where `done`=1 is accepted at E34.
  - `hi`/`lo` keep the previous result until E67.
- MTHI/MTLO take effect at the sampling edge; `hi`/`lo` reflect the new value in the next cycle.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Test plan
- MULTU, `a`=`b`=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001. `busy` is high for exactly 33 cycles and `done` pulses for exactly 1 cycle at E33.
- Signed and unsigned arithmetic:
  - MULT 0xFFFFFFFD x 0x00000007 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB.
  - DIV 0xFFFFFFF9 / 0x00000002 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - DIVU 7 / 2 -> LO=3, HI=1.
- Special cases:
  - DIV 0x12345678 / 0 -> HI=0x12345678, LO=0xFFFFFFFF.
  - DIVU 0x80000000 / 0 -> HI=0x80000000, LO=0xFFFFFFFF.
  - DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- Request handling:
  - `start` pulsed at cycle 5 of CALC with different operands -> ignored; the original result appears at E33.
  - `hi_we`=1 while busy -> `hi` unchanged.
  - MTLO `a`=0xA5A5A5A5 in IDLE -> `lo`=0xA5A5A5A5 next cycle.
- Back-to-back: `start` held high during the `done` cycle -> second op accepted at E34; its `done` arrives at E67 with the correct result.
- Reset mid-operation: `rst`=1 at CALC cycle 10 -> next cycle `busy`=0, `done`=0, `hi`=`lo`=0, and `done` never pulses. A following MULTU 3 x 5 gives LO=15, HI=0 at its own E33.
